// File: rtl/commit_flush_ctrl.sv
// Purpose : commit-stage flush decision (exception / ERET / branch mispredict) with MIPS delay-slot sequencing.
// Latency : exception/ERET commit at t -> flush_req at t+1; mispredict -> flush_req one cycle after its delay slot commits.
// Backpressure: commit_pause holds commits for the FLUSH and RECOVER cycles; WAIT_DS accepts exactly one more commit.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cm_*                        oldest-ROB-entry commit info (valid, pc, branch/mispredict/target, exception/code, eret)
//   cp0_epc                     current CP0 EPC, used as the ERET return target
//   flush_req / commit_pause    to ctrl_commit (flushReq pulse, pauseReq)
//   redirect_valid / redirect_pc  frontend redirect, same cycle as flush_req
//   exc_valid / exc_epc / exc_bd / exc_code  CP0 exception report, same cycle as flush_req
// Optional: define FLUSH_PERF_CNT_EN to add 32-bit perf_mispred_cnt / perf_exc_cnt / perf_eret_cnt outputs.
module commit_flush_ctrl #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cm_valid,
    input  logic [PC_W-1:0] cm_pc,
    input  logic            cm_is_br,
    input  logic            cm_mispred,
    input  logic [PC_W-1:0] cm_target,
    input  logic            cm_exc,
    input  logic [4:0]      cm_exc_code,
    input  logic            cm_eret,
    input  logic [PC_W-1:0] cp0_epc,
    output logic            flush_req,
    output logic            commit_pause,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            exc_valid,
    output logic [PC_W-1:0] exc_epc,
    output logic            exc_bd,
    output logic [4:0]      exc_code
`ifdef FLUSH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_mispred_cnt,
    output logic [31:0]     perf_exc_cnt,
    output logic [31:0]     perf_eret_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_DS, FLUSH, RECOVER} state_t;
    typedef enum logic [1:0] {KIND_NONE, KIND_MISPRED, KIND_EXC, KIND_ERET} kind_t;

    state_t          state, nxtState;
    kind_t           kind, nxtKind;
    logic [PC_W-1:0] target, nxtTarget;
    logic [PC_W-1:0] epc, nxtEpc;
    logic            bd, nxtBd;
    logic [4:0]      code, nxtCode;
    logic [PC_W-1:0] brPc, nxtBrPc;
    logic            dsPending, nxtDsPending;
    logic            nxtInFlush;

    // Next-state and next-latch values. Outputs are registered from these so
    // that commit_pause is already high on the first cycle after the trigger.
    always_comb begin
        nxtState     = state;
        nxtKind      = kind;
        nxtTarget    = target;
        nxtEpc       = epc;
        nxtBd        = bd;
        nxtCode      = code;
        nxtBrPc      = brPc;
        nxtDsPending = dsPending;
        case (state)
            IDLE: begin
                if (cm_valid) begin
                    // Any commit consumes a pending delay slot.
                    nxtDsPending = 1'b0;
                    if (cm_exc) begin
                        // Exception in the delay slot of a correctly predicted
                        // branch reports the branch PC with BD set.
                        nxtState  = FLUSH;
                        nxtKind   = KIND_EXC;
                        nxtTarget = EXC_VECTOR;
                        nxtEpc    = dsPending ? brPc : cm_pc;
                        nxtBd     = dsPending;
                        nxtCode   = cm_exc_code;
                    end else if (cm_eret) begin
                        nxtState  = FLUSH;
                        nxtKind   = KIND_ERET;
                        nxtTarget = cp0_epc;
                    end else if (cm_is_br && cm_mispred) begin
                        nxtState  = WAIT_DS;
                        nxtKind   = KIND_MISPRED;
                        nxtTarget = cm_target;
                        nxtBrPc   = cm_pc;
                    end else if (cm_is_br) begin
                        nxtDsPending = 1'b1;
                        nxtBrPc      = cm_pc;
                    end
                end
            end
            WAIT_DS: begin
                if (cm_valid) begin
                    nxtState = FLUSH;
                    if (cm_exc) begin
                        // Delay-slot exception overrides the mispredict redirect.
                        nxtKind   = KIND_EXC;
                        nxtTarget = EXC_VECTOR;
                        nxtEpc    = brPc;
                        nxtBd     = 1'b1;
                        nxtCode   = cm_exc_code;
                    end
                end
            end
            FLUSH:   nxtState = RECOVER;
            RECOVER: begin
                nxtState = IDLE;
                nxtKind  = KIND_NONE;
            end
            default: nxtState = IDLE;
        endcase
    end

    assign nxtInFlush = (nxtState == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            kind           <= KIND_NONE;
            target         <= '0;
            epc            <= '0;
            bd             <= 1'b0;
            code           <= '0;
            brPc           <= '0;
            dsPending      <= 1'b0;
            flush_req      <= 1'b0;
            commit_pause   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exc_valid      <= 1'b0;
            exc_epc        <= '0;
            exc_bd         <= 1'b0;
            exc_code       <= '0;
        end else begin
            state          <= nxtState;
            kind           <= nxtKind;
            target         <= nxtTarget;
            epc            <= nxtEpc;
            bd             <= nxtBd;
            code           <= nxtCode;
            brPc           <= nxtBrPc;
            dsPending      <= nxtDsPending;
            flush_req      <= nxtInFlush;
            redirect_valid <= nxtInFlush;
            redirect_pc    <= nxtInFlush ? nxtTarget : '0;
            exc_valid      <= nxtInFlush && (nxtKind == KIND_EXC);
            exc_epc        <= (nxtInFlush && nxtKind == KIND_EXC) ? nxtEpc : '0;
            exc_bd         <= nxtInFlush && (nxtKind == KIND_EXC) && nxtBd;
            exc_code       <= (nxtInFlush && nxtKind == KIND_EXC) ? nxtCode : '0;
            commit_pause   <= nxtInFlush || (nxtState == RECOVER);
        end
    end

`ifdef FLUSH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mispred_cnt <= '0;
            perf_exc_cnt     <= '0;
            perf_eret_cnt    <= '0;
        end else if (state == FLUSH) begin
            if (kind == KIND_MISPRED) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
            if (kind == KIND_EXC)     perf_exc_cnt     <= perf_exc_cnt + 32'd1;
            if (kind == KIND_ERET)    perf_eret_cnt    <= perf_eret_cnt + 32'd1;
        end
    end
`endif

    // The commit stage must honour commit_pause; a commit here is dropped.
    noCommitDuringFlush: assert property (@(posedge clk) disable iff (rst)
        !(cm_valid && (state == FLUSH || state == RECOVER)));

endmodule

// File: tb/tb_commit_flush_ctrl.sv
module tb_commit_flush_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cm_valid = 1'b0;
    logic [31:0] cm_pc = '0;
    logic        cm_is_br = 1'b0;
    logic        cm_mispred = 1'b0;
    logic [31:0] cm_target = '0;
    logic        cm_exc = 1'b0;
    logic [4:0]  cm_exc_code = '0;
    logic        cm_eret = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        flush_req, commit_pause, redirect_valid, exc_valid, exc_bd;
    logic [31:0] redirect_pc, exc_epc;
    logic [4:0]  exc_code;
`ifdef FLUSH_PERF_CNT_EN
    logic [31:0] perf_mispred_cnt, perf_exc_cnt, perf_eret_cnt;
`endif
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    commit_flush_ctrl dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_is_br(cm_is_br), .cm_mispred(cm_mispred),
        .cm_target(cm_target), .cm_exc(cm_exc), .cm_exc_code(cm_exc_code), .cm_eret(cm_eret),
        .cp0_epc(cp0_epc),
        .flush_req(flush_req), .commit_pause(commit_pause),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_bd(exc_bd), .exc_code(exc_code)
`ifdef FLUSH_PERF_CNT_EN
        , .perf_mispred_cnt(perf_mispred_cnt), .perf_exc_cnt(perf_exc_cnt), .perf_eret_cnt(perf_eret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic isBr, input logic mis,
                          input logic [31:0] tgt, input logic exc, input logic [4:0] code,
                          input logic eret);
        cm_valid = 1'b1; cm_pc = pc; cm_is_br = isBr; cm_mispred = mis;
        cm_target = tgt; cm_exc = exc; cm_exc_code = code; cm_eret = eret;
    endtask

    task automatic idle();
        cm_valid = 1'b0; cm_is_br = 1'b0; cm_mispred = 1'b0; cm_exc = 1'b0; cm_eret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); tick(); tick();
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush_req); end
        checks++; if (commit_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %0b want 0", commit_pause); end
        checks++; if ({redirect_valid, exc_valid, exc_bd} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {redirect_valid, exc_valid, exc_bd}); end
        checks++; if ({redirect_pc, exc_epc, exc_code} !== 69'd0) begin errors++; $display("FAIL reset_data got %h want 0", {redirect_pc, exc_epc, exc_code}); end
        rst = 1'b0;
    endtask

    task automatic test_exception();
        commit(32'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b1, 5'h0C, 1'b0); tick(); idle();
        checks++; if ({flush_req, redirect_valid, exc_valid, commit_pause} !== 4'b1111) begin errors++; $display("FAIL exc_strobes got %b want 1111", {flush_req, redirect_valid, exc_valid, commit_pause}); end
        checks++; if (redirect_pc !== VEC) begin errors++; $display("FAIL exc_redirect got %h want %h", redirect_pc, VEC); end
        checks++; if (exc_epc !== 32'h8000_0100) begin errors++; $display("FAIL exc_epc got %h want 80000100", exc_epc); end
        checks++; if (exc_bd !== 1'b0) begin errors++; $display("FAIL exc_bd got %0b want 0", exc_bd); end
        checks++; if (exc_code !== 5'h0C) begin errors++; $display("FAIL exc_code got %h want 0c", exc_code); end
        tick();
        checks++; if ({flush_req, commit_pause} !== 2'b01) begin errors++; $display("FAIL exc_recover got %b want 01", {flush_req, commit_pause}); end
        tick();
        checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL exc_idle got %b want 00", {flush_req, commit_pause}); end
    endtask

    task automatic test_mispredict();
        commit(32'h8000_0200, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 5'h0, 1'b0); tick(); idle();
        for (int i = 1; i <= 3; i++) begin
            checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL mis_wait%0d got %b want 00", i, {flush_req, commit_pause}); end
            if (i < 3) tick();
        end
        commit(32'h8000_0204, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick(); idle();
        checks++; if ({flush_req, redirect_valid, exc_valid, commit_pause} !== 4'b1101) begin errors++; $display("FAIL mis_strobes got %b want 1101", {flush_req, redirect_valid, exc_valid, commit_pause}); end
        checks++; if (redirect_pc !== 32'h8000_1000) begin errors++; $display("FAIL mis_redirect got %h want 80001000", redirect_pc); end
        tick(); tick();
        checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL mis_idle got %b want 00", {flush_req, commit_pause}); end
    endtask

    task automatic test_ds_exception();
        commit(32'h8000_0300, 1'b1, 1'b1, 32'h8000_2000, 1'b0, 5'h0, 1'b0); tick();
        commit(32'h8000_0304, 1'b0, 1'b0, 32'h0, 1'b1, 5'h04, 1'b0); tick(); idle();
        checks++; if ({flush_req, exc_valid} !== 2'b11) begin errors++; $display("FAIL dsexc_strobes got %b want 11", {flush_req, exc_valid}); end
        checks++; if (redirect_pc !== VEC) begin errors++; $display("FAIL dsexc_redirect got %h want %h", redirect_pc, VEC); end
        checks++; if (exc_epc !== 32'h8000_0300) begin errors++; $display("FAIL dsexc_epc got %h want 80000300", exc_epc); end
        checks++; if ({exc_bd, exc_code} !== 6'b1_00100) begin errors++; $display("FAIL dsexc_bd_code got %b want 100100", {exc_bd, exc_code}); end
        tick(); tick();
    endtask

    task automatic test_eret();
        cp0_epc = 32'h8000_0444;
        commit(32'h8000_0400, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b1); tick(); idle();
        checks++; if ({flush_req, redirect_valid, exc_valid} !== 3'b110) begin errors++; $display("FAIL eret_strobes got %b want 110", {flush_req, redirect_valid, exc_valid}); end
        checks++; if (redirect_pc !== 32'h8000_0444) begin errors++; $display("FAIL eret_redirect got %h want 80000444", redirect_pc); end
        tick(); tick();
    endtask

    task automatic test_exc_eret_priority();
        commit(32'h8000_0500, 1'b0, 1'b0, 32'h0, 1'b1, 5'h0D, 1'b1); tick(); idle();
        checks++; if ({flush_req, exc_valid} !== 2'b11) begin errors++; $display("FAIL prio_strobes got %b want 11", {flush_req, exc_valid}); end
        checks++; if (redirect_pc !== VEC) begin errors++; $display("FAIL prio_redirect got %h want %h", redirect_pc, VEC); end
        checks++; if (exc_epc !== 32'h8000_0500) begin errors++; $display("FAIL prio_epc got %h want 80000500", exc_epc); end
        tick(); tick();
    endtask

    task automatic test_ds_pending_bd();
        // Correctly predicted branch: the following exception reports the branch PC with BD.
        commit(32'h8000_0600, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick();
        checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL okbr_noflush got %b want 00", {flush_req, commit_pause}); end
        commit(32'h8000_0604, 1'b0, 1'b0, 32'h0, 1'b1, 5'h0A, 1'b0); tick(); idle();
        checks++; if (exc_epc !== 32'h8000_0600) begin errors++; $display("FAIL dsbd_epc got %h want 80000600", exc_epc); end
        checks++; if (exc_bd !== 1'b1) begin errors++; $display("FAIL dsbd_bd got %0b want 1", exc_bd); end
        tick(); tick();
        // The pending delay slot is consumed by one commit.
        commit(32'h8000_0700, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick();
        commit(32'h8000_0704, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick();
        commit(32'h8000_0708, 1'b0, 1'b0, 32'h0, 1'b1, 5'h0A, 1'b0); tick(); idle();
        checks++; if ({exc_bd, exc_epc} !== {1'b0, 32'h8000_0708}) begin errors++; $display("FAIL dsclr got bd=%0b epc=%h want bd=0 epc=80000708", exc_bd, exc_epc); end
        tick(); tick();
    endtask

    task automatic test_wait_indefinite();
        commit(32'h8000_0800, 1'b1, 1'b1, 32'h8000_3000, 1'b0, 5'h0, 1'b0); tick(); idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL waitds%0d got %b want 00", i, {flush_req, commit_pause}); end
        end
        commit(32'h8000_0804, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick(); idle();
        checks++; if ({flush_req, redirect_pc} !== {1'b1, 32'h8000_3000}) begin errors++; $display("FAIL waitds_flush got %b/%h want 1/80003000", flush_req, redirect_pc); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        commit(32'h8000_0900, 1'b0, 1'b0, 32'h0, 1'b1, 5'h01, 1'b0); tick(); idle(); tick(); tick();
        commit(32'h8000_0904, 1'b0, 1'b0, 32'h0, 1'b1, 5'h02, 1'b0); tick(); idle();
        checks++; if ({flush_req, exc_epc, exc_code} !== {1'b1, 32'h8000_0904, 5'h02}) begin errors++; $display("FAIL b2b got %b/%h/%h want 1/80000904/02", flush_req, exc_epc, exc_code); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        commit(32'h8000_0A00, 1'b1, 1'b1, 32'h8000_4000, 1'b0, 5'h0, 1'b0); tick(); idle();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({flush_req, commit_pause, redirect_valid, exc_valid, redirect_pc} !== 36'd0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", {flush_req, commit_pause, redirect_valid, exc_valid, redirect_pc}); end
        // A plain commit after reset must not be taken as the old delay slot.
        commit(32'h8000_0A04, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({flush_req, commit_pause} !== 2'b00) begin errors++; $display("FAIL rstmid_noflush%0d got %b want 00", i, {flush_req, commit_pause}); end
            tick();
        end
    endtask

`ifdef FLUSH_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit(32'h8000_0B00, 1'b1, 1'b1, 32'h8000_5000, 1'b0, 5'h0, 1'b0); tick();
            commit(32'h8000_0B04, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0); tick(); idle(); tick(); tick();
        end
        commit(32'h8000_0C00, 1'b0, 1'b0, 32'h0, 1'b1, 5'h03, 1'b0); tick(); idle(); tick(); tick();
        checks++; if (perf_mispred_cnt !== 32'd3) begin errors++; $display("FAIL perf_mispred got %0d want 3", perf_mispred_cnt); end
        checks++; if (perf_exc_cnt !== 32'd1) begin errors++; $display("FAIL perf_exc got %0d want 1", perf_exc_cnt); end
        checks++; if (perf_eret_cnt !== 32'd0) begin errors++; $display("FAIL perf_eret got %0d want 0", perf_eret_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_exception();
        test_mispredict();
        test_ds_exception();
        test_eret();
        test_exc_eret_priority();
        test_ds_pending_bd();
        test_wait_indefinite();
        test_back_to_back();
        test_reset_mid();
`ifdef FLUSH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
